// File: rtl/frame_arb_pkg.sv
// Shared types and helpers for the frame-granular round-robin arbiter.
// Latency: n/a (types and a combinational search function only).
// Backpressure: n/a.
package frame_arb_pkg;

    // Upper bound on requesters the status source field can encode.
    localparam int unsigned MAX_SRC_W = 4;
    localparam int unsigned MAX_REQ   = 1 << MAX_SRC_W;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Status travelling alongside each data beat through the output pipe.
    typedef struct packed {
        logic                 valid;
        logic                 last;
        logic                 err;
        logic [MAX_SRC_W-1:0] src;
    } arb_status_t;

    // Round-robin search: first index with req set, starting at last+1 (mod n).
    // Result MSB is the hit flag, low bits are the chosen index.
    function automatic logic [MAX_SRC_W:0] rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_SRC_W-1:0] last,
        input int unsigned          n
    );
        logic [MAX_SRC_W:0] res;
        int unsigned        base;
        int unsigned        idx;
        res  = '0;
        base = 32'(last);
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !res[MAX_SRC_W]) begin
                idx = (base + k) % n;
                if (req[idx[MAX_SRC_W-1:0]]) begin
                    res = {1'b1, idx[MAX_SRC_W-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_status_pipeline.sv
// Register pipeline carrying a data word plus a status word side by side.
// Latency: DEPTH cycles from input to output.
// Backpressure: none; every cycle advances, status stages reset to zero, data is not reset.
module data_status_pipeline #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned STATUS_W = 1,
    parameter int unsigned DEPTH    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [STATUS_W-1:0] status_i,
    output logic [DATA_W-1:0]   data_o,
    output logic [STATUS_W-1:0] status_o
);

    logic [DATA_W-1:0]   data_d   [DEPTH];
    logic [DATA_W-1:0]   data_q   [DEPTH];
    logic [STATUS_W-1:0] status_d [DEPTH];
    logic [STATUS_W-1:0] status_q [DEPTH];

    // Each stage takes the previous stage; stage 0 takes the inputs.
    always_comb begin
        data_d[0]   = data_i;
        status_d[0] = status_i;
        for (int i = 1; i < DEPTH; i++) begin
            data_d[i]   = data_q[i-1];
            status_d[i] = status_q[i-1];
        end
    end

    // Data stages are free-running; their value only matters alongside valid status.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    // Status stages flush on reset so no stale beat escapes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                status_q[i] <= '0;
            end else begin
                status_q[i] <= status_d[i];
            end
        end
    end

    assign data_o   = data_q[DEPTH-1];
    assign status_o = status_q[DEPTH-1];

endmodule

// File: rtl/frame_rr_arbiter.sv
// Frame-granular round-robin arbiter: locks on one requester from first beat to last beat.
// Latency: beat appears PIPE_DEPTH cycles after acceptance; one idle bubble between frames.
// Backpressure: req_ready_o is one-hot on the granted requester in GRANT, zero in IDLE.
// Optional FRAME_ARB_TIMEOUT_EN: abort a frame with an err beat after TIMEOUT_CYCLES idle beats.
module frame_rr_arbiter
    import frame_arb_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned PIPE_DEPTH     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [DATA_W-1:0]           data_o,
    output logic                        valid_o,
    output logic                        last_o,
    output logic [$clog2(NUM_REQ)-1:0]  src_o,
    output logic                        err_o,
    output logic                        busy_o
);

    localparam int unsigned SRC_W    = $clog2(NUM_REQ);
    localparam int unsigned STATUS_W = $bits(arb_status_t);

    arb_state_t         state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_SRC_W-1:0] last_pad;
    logic [MAX_SRC_W:0] pick;
    logic               gnt_vld;
    logic               gnt_last;
    logic [DATA_W-1:0]  gnt_dat;
    logic               accept;
    logic               abort;
    arb_status_t        st_in;
    arb_status_t        st_out;

    // View of the granted requester and the round-robin candidate for IDLE.
    always_comb begin
        req_pad                   = '0;
        req_pad[NUM_REQ-1:0]      = req_valid_i;
        last_pad                  = '0;
        last_pad[SRC_W-1:0]       = last_grant_q;
        pick                      = rr_pick(req_pad, last_pad, NUM_REQ);
        gnt_vld                   = req_valid_i[grant_q];
        gnt_last                  = req_last_i[grant_q];
        gnt_dat                   = req_data_i[grant_q*DATA_W +: DATA_W];
        accept                    = (state_q == GRANT) && gnt_vld;
    end

`ifdef FRAME_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Count stalled cycles of the owner; an accepted beat always wins over the abort.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        abort     = 1'b0;
        if (state_q != GRANT || accept) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES)) begin
            abort     = 1'b1;
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Next-state: pick a winner in IDLE, hold it until its last beat (or abort).
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick[MAX_SRC_W]) begin
                    grant_d = pick[SRC_W-1:0];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if ((accept && gnt_last) || abort) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state; last_grant resets to the top index so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Status injected into the pipe; all-zero on cycles with nothing to send.
    always_comb begin
        st_in = '0;
        if (accept || abort) begin
            st_in.valid          = 1'b1;
            st_in.last           = abort ? 1'b1 : gnt_last;
            st_in.err            = abort;
            st_in.src[SRC_W-1:0] = grant_q;
        end
    end

    // Only the owner sees ready, and only while the grant is held.
    always_comb begin
        req_ready_o = '0;
        if (state_q == GRANT) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    data_status_pipeline #(
        .DATA_W   (DATA_W),
        .STATUS_W (STATUS_W),
        .DEPTH    (PIPE_DEPTH)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .data_i   (gnt_dat),
        .status_i (st_in),
        .data_o   (data_o),
        .status_o (st_out)
    );

    assign busy_o  = (state_q == GRANT);
    assign valid_o = st_out.valid;
    assign last_o  = st_out.last;
    assign src_o   = st_out.src[SRC_W-1:0];

`ifdef FRAME_ARB_TIMEOUT_EN
    assign err_o = st_out.err;
    logic unused_bits;
    assign unused_bits = ^{st_out.src >> SRC_W, pick >> SRC_W};
`else
    assign err_o = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{st_out.err, st_out.src >> SRC_W, pick >> SRC_W, TIMEOUT_CYCLES};
`endif

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Randomized and directed bench for frame_rr_arbiter against a frame-level reference model.
// Latency: model predicts each output beat PIPE_DEPTH cycles after acceptance.
// Backpressure: requesters advance only on the model's predicted accept.
module tb_frame_rr_arbiter;

    localparam int DATA_W     = 8;
    localparam int NUM_REQ    = 4;
    localparam int PIPE_DEPTH = 1;
    localparam int TMO        = 8;
    localparam int SRC_W      = $clog2(NUM_REQ);
    localparam int QD         = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_last_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [DATA_W-1:0]         data_o;
    logic                      valid_o;
    logic                      last_o;
    logic [SRC_W-1:0]          src_o;
    logic                      err_o;
    logic                      busy_o;

    always #5 clk = ~clk;

    frame_rr_arbiter #(
        .DATA_W         (DATA_W),
        .NUM_REQ        (NUM_REQ),
        .PIPE_DEPTH     (PIPE_DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
        .src_o       (src_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        bit                l;
    } item_t;

    typedef struct {
        bit                v;
        bit                l;
        bit                e;
        int                s;
        logic [DATA_W-1:0] d;
    } beat_t;

    // Per-requester pending beats (ring buffers).
    item_t mem [NUM_REQ][QD];
    int    hd  [NUM_REQ];
    int    tl  [NUM_REQ];
    logic [NUM_REQ-1:0] gate;

    // Reference model: who owns the link, who went last, stalled cycles, beats in flight.
    bit    m_busy;
    int    m_owner;
    int    m_last;
    int    m_stall;
    beat_t m_pipe [PIPE_DEPTH];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int r, input int len, input int base);
        for (int i = 0; i < len; i++) begin
            if (tl[r] - hd[r] < QD) begin
                mem[r][tl[r] % QD].d = DATA_W'(base + i);
                mem[r][tl[r] % QD].l = (i == len - 1);
                tl[r]++;
            end
        end
    endtask

    task automatic clear_queues();
        for (int r = 0; r < NUM_REQ; r++) hd[r] = tl[r];
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = NUM_REQ - 1;
        m_stall = 0;
        for (int i = 0; i < PIPE_DEPTH; i++) m_pipe[i] = '{v: 0, l: 0, e: 0, s: 0, d: '0};
    endtask

    // One clock: drive, check at the falling edge, advance the model.
    task automatic step();
        logic [NUM_REQ-1:0]        v, l, exp_rdy;
        logic [NUM_REQ*DATA_W-1:0] d;
        beat_t                     cur, ob;
        int                        acc;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (tl[r] != hd[r] && gate[r]) begin
                v[r] = 1'b1;
                l[r] = mem[r][hd[r] % QD].l;
                d[r*DATA_W +: DATA_W] = mem[r][hd[r] % QD].d;
            end else begin
                v[r] = 1'b0;
                l[r] = 1'($urandom);
                d[r*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
        end
        req_valid_i = v;
        req_last_i  = l;
        req_data_i  = d;

        @(negedge clk);
        exp_rdy = '0;
        if (m_busy) exp_rdy[m_owner] = 1'b1;
        ob = m_pipe[PIPE_DEPTH-1];
        check_eq("ready", 32'(req_ready_o), 32'(exp_rdy));
        check_eq("busy",  32'(busy_o),      32'(m_busy));
        check_eq("valid", 32'(valid_o),     32'(ob.v));
        check_eq("last",  32'(last_o),      32'(ob.l));
        check_eq("src",   32'(src_o),       32'(ob.s));
        check_eq("err",   32'(err_o),       32'(ob.e));
        if (ob.v && !ob.e) check_eq("data", 32'(data_o), 32'(ob.d));

        cur = '{v: 0, l: 0, e: 0, s: 0, d: '0};
        acc = -1;
        if (!m_busy) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int i;
                i = (m_last + k) % NUM_REQ;
                if (!m_busy && v[i]) begin
                    m_busy  = 1;
                    m_owner = i;
                    m_stall = 0;
                end
            end
        end else if (v[m_owner]) begin
            cur.v   = 1;
            cur.l   = l[m_owner];
            cur.s   = m_owner;
            cur.d   = d[m_owner*DATA_W +: DATA_W];
            acc     = m_owner;
            m_stall = 0;
            if (l[m_owner]) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end else begin
`ifdef FRAME_ARB_TIMEOUT_EN
            if (m_stall == TMO) begin
                cur.v   = 1;
                cur.l   = 1;
                cur.e   = 1;
                cur.s   = m_owner;
                m_busy  = 0;
                m_last  = m_owner;
                m_stall = 0;
            end else begin
                m_stall++;
            end
`endif
        end
        for (int i = PIPE_DEPTH - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = cur;
        if (acc >= 0) hd[acc]++;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain(input int maxc);
        int  c;
        bit  pending;
        c = 0;
        pending = 1;
        while (pending && c < maxc) begin
            step();
            c++;
            pending = 0;
            for (int r = 0; r < NUM_REQ; r++) if (tl[r] != hd[r]) pending = 1;
        end
        check_eq("drain_bound", 32'(pending), 32'(0));
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic run_until_hd(input int r, input int target, input int maxc);
        int c;
        c = 0;
        while (hd[r] < target && c < maxc) begin
            step();
            c++;
        end
        check_eq("wait_bound", 32'(hd[r] >= target), 32'(1));
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        gate        = '1;
        for (int r = 0; r < NUM_REQ; r++) begin
            hd[r] = 0;
            tl[r] = 0;
        end
        @(posedge clk);
        #1;
        do_reset();
        step();
        step();

        // Requester 1 sends A1..A3, requester 2 a single beat after one bubble.
        push_frame(1, 3, 'hA1);
        push_frame(2, 1, 'hB1);
        drain(40);

        // Everyone streams single-beat frames: order 0,1,2,3,0.
        do_reset();
        for (int r = 0; r < NUM_REQ; r++) push_frame(r, 1, 'h10 * r + 1);
        push_frame(0, 1, 'h55);
        drain(60);

        // Owner drops valid for 5 cycles mid-frame while requester 3 waits.
        do_reset();
        push_frame(0, 3, 'hC0);
        push_frame(3, 1, 'hD0);
        run_until_hd(0, 1, 20);
        gate[0] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        gate[0] = 1'b1;
        drain(40);

        // Reset in the middle of a frame, then upstream restarts.
        do_reset();
        push_frame(0, 4, 'hE0);
        push_frame(1, 2, 'hF0);
        run_until_hd(0, 2, 20);
        do_reset();
        clear_queues();
        step();
        push_frame(0, 2, 'h20);
        push_frame(1, 2, 'h30);
        push_frame(2, 1, 'h40);
        drain(40);

        // Owner stalls for 100 cycles while requester 2 waits.
        do_reset();
        push_frame(1, 2, 'h60);
        push_frame(2, 1, 'h70);
        run_until_hd(1, 1, 20);
        gate[1] = 1'b0;
        for (int i = 0; i < 100; i++) step();
        gate[1] = 1'b1;
        drain(60);

        // Random traffic with random valid gaps.
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (tl[r] - hd[r] < 8 && $urandom_range(7) == 0)
                    push_frame(r, 1 + $urandom_range(3), int'($urandom));
                gate[r] = ($urandom_range(3) != 0);
            end
            step();
        end
        gate = '1;
        drain(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
